// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: requests the word at the current PC, latches the
// returned instruction and strobes the next PC (sequential step or redirect target).
//
// state | meaning
// IDLE  | no fetch in flight, instr not valid
// FETCH | request outstanding, waiting for imem_ack_i
// HOLD  | fetch complete, instr_o valid until the next start
module fetch_unit #(
    parameter int BUS_WIDTH = 32,
    parameter int PC_STEP   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [BUS_WIDTH-1:0] curr_addr_i,
    input  logic                 redirect_i,
    input  logic [BUS_WIDTH-1:0] redirect_addr_i,
    output logic                 imem_req_o,
    output logic [BUS_WIDTH-1:0] imem_addr_o,
    input  logic                 imem_ack_i,
    input  logic [BUS_WIDTH-1:0] imem_rdata_i,
    output logic [BUS_WIDTH-1:0] instr_o,
    output logic                 instr_valid_o,
    output logic                 pc_update_o,
    output logic [BUS_WIDTH-1:0] next_addr_o,
    output logic                 busy_o,
    output logic                 misaligned_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [BUS_WIDTH-1:0] STEP = BUS_WIDTH'(PC_STEP);

    state_t               state_q, state_d;
    logic                 imem_req_q, imem_req_d;
    logic [BUS_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [BUS_WIDTH-1:0] instr_q, instr_d;
    logic                 instr_valid_q, instr_valid_d;
    logic                 pc_update_q, pc_update_d;
    logic [BUS_WIDTH-1:0] next_addr_q, next_addr_d;
    logic                 busy_q, busy_d;
    logic                 misaligned_q, misaligned_d;
    logic                 start_pending_q, start_pending_d;
    logic                 redir_pending_q, redir_pending_d;
    logic [BUS_WIDTH-1:0] redir_addr_q, redir_addr_d;
    logic                 start_eff;

    // A start deferred by a same-cycle redirect fires once the PC has been reloaded.
    assign start_eff = start_i | start_pending_q;

    always_comb begin
        state_d         = state_q;
        imem_req_d      = imem_req_q;
        imem_addr_d     = imem_addr_q;
        instr_d         = instr_q;
        instr_valid_d   = instr_valid_q;
        pc_update_d     = 1'b0;
        next_addr_d     = next_addr_q;
        busy_d          = busy_q;
        misaligned_d    = misaligned_q;
        start_pending_d = start_pending_q;
        redir_pending_d = redir_pending_q;
        redir_addr_d    = redir_addr_q;

        case (state_q)
            IDLE, HOLD: begin
                if (redirect_i) begin
                    pc_update_d = 1'b1;
                    next_addr_d = redirect_addr_i;
                    if (start_eff) begin
                        start_pending_d = 1'b1;
                    end
                end else if (start_eff) begin
                    start_pending_d = 1'b0;
                    instr_valid_d   = 1'b0;
                    if (curr_addr_i[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        misaligned_d = 1'b0;
                        state_d      = FETCH;
                        imem_addr_d  = curr_addr_i;
                        imem_req_d   = 1'b1;
                        busy_d       = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (imem_ack_i) begin
                    instr_d         = imem_rdata_i;
                    instr_valid_d   = 1'b1;
                    pc_update_d     = 1'b1;
                    imem_req_d      = 1'b0;
                    busy_d          = 1'b0;
                    redir_pending_d = 1'b0;
                    state_d         = HOLD;
                    // A redirect arriving with the ack is the newest target and wins.
                    if (redirect_i) begin
                        next_addr_d = redirect_addr_i;
                    end else if (redir_pending_q) begin
                        next_addr_d = redir_addr_q;
                    end else begin
                        next_addr_d = imem_addr_q + STEP;
                    end
                end else if (redirect_i) begin
                    redir_pending_d = 1'b1;
                    redir_addr_d    = redirect_addr_i;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            imem_req_q      <= 1'b0;
            imem_addr_q     <= '0;
            instr_q         <= '0;
            instr_valid_q   <= 1'b0;
            pc_update_q     <= 1'b0;
            next_addr_q     <= '0;
            busy_q          <= 1'b0;
            misaligned_q    <= 1'b0;
            start_pending_q <= 1'b0;
            redir_pending_q <= 1'b0;
            redir_addr_q    <= '0;
        end else begin
            state_q         <= state_d;
            imem_req_q      <= imem_req_d;
            imem_addr_q     <= imem_addr_d;
            instr_q         <= instr_d;
            instr_valid_q   <= instr_valid_d;
            pc_update_q     <= pc_update_d;
            next_addr_q     <= next_addr_d;
            busy_q          <= busy_d;
            misaligned_q    <= misaligned_d;
            start_pending_q <= start_pending_d;
            redir_pending_q <= redir_pending_d;
            redir_addr_q    <= redir_addr_d;
        end
    end

    assign imem_req_o    = imem_req_q;
    assign imem_addr_o   = imem_addr_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign pc_update_o   = pc_update_q;
    assign next_addr_o   = next_addr_q;
    assign busy_o        = busy_q;
    assign misaligned_o  = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; models a PC register that loads next_addr
// between falling edges whenever pc_update is seen.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] curr_addr_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        pc_update_o;
    logic [31:0] next_addr_o;
    logic        busy_o;
    logic        misaligned_o;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.BUS_WIDTH(32), .PC_STEP(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .curr_addr_i    (curr_addr_i),
        .redirect_i     (redirect_i),
        .redirect_addr_i(redirect_addr_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_rdata_i   (imem_rdata_i),
        .instr_o        (instr_o),
        .instr_valid_o  (instr_valid_o),
        .pc_update_o    (pc_update_o),
        .next_addr_o    (next_addr_o),
        .busy_o         (busy_o),
        .misaligned_o   (misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one active (falling) edge and sample just after it.
    task automatic tick();
        @(negedge clk_i);
        #1;
        if (pc_update_o) curr_addr_i = next_addr_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = '0;
        imem_ack_i = 1'b0; imem_rdata_i = '0; curr_addr_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        checks++;
        if ({imem_req_o, instr_valid_o, pc_update_o, busy_o, misaligned_o} !== 5'b0 ||
            imem_addr_o !== 32'h0 || instr_o !== 32'h0 || next_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b addr=%h instr=%h v=%b pcu=%b next=%h busy=%b mis=%b, all zero required",
                     imem_req_o, imem_addr_o, instr_o, instr_valid_o, pc_update_o, next_addr_o, busy_o, misaligned_o);
        end
    endtask

    task automatic test_basic();
        curr_addr_i = 32'h100; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || busy_o !== 1'b1 || pc_update_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_req: req=%b addr=%h busy=%b pcu=%b, required 1 00000100 1 0",
                     imem_req_o, imem_addr_o, busy_o, pc_update_o);
        end
        imem_ack_i = 1'b1; imem_rdata_i = 32'h00500093;
        tick();
        imem_ack_i = 1'b0;
        checks++;
        if (imem_req_o !== 1'b0 || busy_o !== 1'b0 || instr_o !== 32'h00500093 ||
            instr_valid_o !== 1'b1 || pc_update_o !== 1'b1 || next_addr_o !== 32'h104) begin
            failures++;
            $display("FAIL basic_done: req=%b busy=%b instr=%h v=%b pcu=%b next=%h, required 0 0 00500093 1 1 00000104",
                     imem_req_o, busy_o, instr_o, instr_valid_o, pc_update_o, next_addr_o);
        end
        tick();
        checks++;
        if (pc_update_o !== 1'b0 || instr_valid_o !== 1'b1 || instr_o !== 32'h00500093) begin
            failures++;
            $display("FAIL basic_hold: pcu=%b v=%b instr=%h, required 0 1 00500093",
                     pc_update_o, instr_valid_o, instr_o);
        end
    endtask

    task automatic test_wait_states();
        curr_addr_i = 32'h100; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || busy_o !== 1'b1 || pc_update_o !== 1'b0) begin
                failures++;
                $display("FAIL wait_cycle%0d: req=%b addr=%h busy=%b pcu=%b, required 1 00000100 1 0",
                         i, imem_req_o, imem_addr_o, busy_o, pc_update_o);
            end
            if (i == 3) begin
                imem_ack_i = 1'b1; imem_rdata_i = 32'h12345678;
            end
            tick();
        end
        imem_ack_i = 1'b0;
        checks++;
        if (pc_update_o !== 1'b1 || next_addr_o !== 32'h104 || instr_o !== 32'h12345678 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL wait_done: pcu=%b next=%h instr=%h busy=%b, required 1 00000104 12345678 0",
                     pc_update_o, next_addr_o, instr_o, busy_o);
        end
        tick();
        checks++;
        if (pc_update_o !== 1'b0) begin
            failures++;
            $display("FAIL wait_single_pcu: pcu=%b, required 0", pc_update_o);
        end
    endtask

    task automatic test_wrap();
        curr_addr_i = 32'hFFFFFFFC; start_i = 1'b1;
        tick();
        start_i = 1'b0; imem_ack_i = 1'b1; imem_rdata_i = 32'hCAFEF00D;
        tick();
        imem_ack_i = 1'b0;
        checks++;
        if (pc_update_o !== 1'b1 || next_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL wrap: pcu=%b next=%h, required 1 00000000", pc_update_o, next_addr_o);
        end
        tick();
    endtask

    task automatic test_redirect_mid();
        curr_addr_i = 32'h100; start_i = 1'b1;
        tick();
        start_i = 1'b0; redirect_i = 1'b1; redirect_addr_i = 32'h2000;
        tick();
        redirect_i = 1'b0;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || pc_update_o !== 1'b0) begin
            failures++;
            $display("FAIL redir_mid_wait: req=%b addr=%h pcu=%b, required 1 00000100 0",
                     imem_req_o, imem_addr_o, pc_update_o);
        end
        imem_ack_i = 1'b1; imem_rdata_i = 32'h0000006F;
        tick();
        imem_ack_i = 1'b0;
        checks++;
        if (pc_update_o !== 1'b1 || next_addr_o !== 32'h2000) begin
            failures++;
            $display("FAIL redir_mid_target: pcu=%b next=%h, required 1 00002000", pc_update_o, next_addr_o);
        end
        tick();
        // Redirect arriving together with the ack.
        start_i = 1'b1;
        tick();
        start_i = 1'b0; imem_ack_i = 1'b1; redirect_i = 1'b1; redirect_addr_i = 32'h3000;
        tick();
        imem_ack_i = 1'b0; redirect_i = 1'b0;
        checks++;
        if (pc_update_o !== 1'b1 || next_addr_o !== 32'h3000) begin
            failures++;
            $display("FAIL redir_with_ack: pcu=%b next=%h, required 1 00003000", pc_update_o, next_addr_o);
        end
        tick();
    endtask

    task automatic test_start_redirect_hold();
        start_i = 1'b1; redirect_i = 1'b1; redirect_addr_i = 32'h400;
        tick();
        start_i = 1'b0; redirect_i = 1'b0;
        checks++;
        if (pc_update_o !== 1'b1 || next_addr_o !== 32'h400 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL start_redir_pcu: pcu=%b next=%h req=%b v=%b, required 1 00000400 0 1",
                     pc_update_o, next_addr_o, imem_req_o, instr_valid_o);
        end
        tick();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h400 || pc_update_o !== 1'b0 || instr_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL start_redir_fetch: req=%b addr=%h pcu=%b v=%b, required 1 00000400 0 0",
                     imem_req_o, imem_addr_o, pc_update_o, instr_valid_o);
        end
        imem_ack_i = 1'b1;
        tick();
        imem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_misaligned();
        curr_addr_i = 32'h102; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if (misaligned_o !== 1'b1 || imem_req_o !== 1'b0 || pc_update_o !== 1'b0 ||
            instr_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_flag: mis=%b req=%b pcu=%b v=%b busy=%b, required 1 0 0 0 0",
                     misaligned_o, imem_req_o, pc_update_o, instr_valid_o, busy_o);
        end
        tick();
        checks++;
        if (misaligned_o !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_sticky: mis=%b, required 1", misaligned_o);
        end
        curr_addr_i = 32'h100; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if (misaligned_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
            failures++;
            $display("FAIL misaligned_clear: mis=%b req=%b addr=%h, required 0 1 00000100",
                     misaligned_o, imem_req_o, imem_addr_o);
        end
        imem_ack_i = 1'b1;
        tick();
        imem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        curr_addr_i = 32'h200; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if ({imem_req_o, instr_valid_o, pc_update_o, busy_o, misaligned_o} !== 5'b0 ||
            imem_addr_o !== 32'h0 || instr_o !== 32'h0 || next_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs: req=%b addr=%h instr=%h v=%b pcu=%b next=%h busy=%b mis=%b, all zero required",
                     imem_req_o, imem_addr_o, instr_o, instr_valid_o, pc_update_o, next_addr_o, busy_o, misaligned_o);
        end
        imem_ack_i = 1'b1; imem_rdata_i = 32'hDEADBEEF;
        tick();
        imem_ack_i = 1'b0;
        checks++;
        if (instr_o !== 32'h0 || instr_valid_o !== 1'b0 || pc_update_o !== 1'b0 || imem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_late_ack: instr=%h v=%b pcu=%b req=%b, required 00000000 0 0 0",
                     instr_o, instr_valid_o, pc_update_o, imem_req_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_wrap();
        test_redirect_mid();
        test_start_redirect_hold();
        test_misaligned();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
